// File: rtl/mdl_dmabusmaster.sv
// 68000-style DMA bus master: BR/BG/BGACK arbitration plus word-sized AS/UDS/LDS bus cycles
// driven from the DMA timing stage, with grant and DTACK watchdogs.
module mdl_dmabusmaster #(
  parameter int unsigned AW        = 23,
  parameter int unsigned BG_TMO    = 255,
  parameter int unsigned DTACK_TMO = 63
) (
  input  logic          i_MCLK,
  input  logic          i_SYS_RST,
  input  logic          i_CLK4M_PCEN_n,
  input  logic          i_BR_START_n,
  input  logic          i_DMA_END,
  input  logic          i_WORD_REQ,
  input  logic          i_DMA_WR_ACT_n,
  input  logic          i_ADDR_LD,
  input  logic [AW-1:0] i_ADDR_D,
  input  logic          i_BG_n,
  input  logic          i_AS_n,
  input  logic          i_DTACK_n,
  output logic          o_BR_n,
  output logic          o_BGACK_n,
  output logic          o_AS_n,
  output logic          o_UDS_n,
  output logic          o_LDS_n,
  output logic          o_RW,
  output logic [AW-1:0] o_ADDR,
  output logic          o_DMA_ACT,
  output logic          o_WORD_DONE,
  output logic          o_BUSERR
);

  localparam int unsigned BGW = $clog2(BG_TMO + 1);
  localparam int unsigned DTW = $clog2(DTACK_TMO + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_OWN,
    ST_AS,
    ST_DS,
    ST_WT,
    ST_END,
    ST_REL
  } state_e;

  state_e         state_q, state_d;
  logic           br_n_q, br_n_d;
  logic           bgack_n_q, bgack_n_d;
  logic           as_n_q, as_n_d;
  logic           ds_n_q, ds_n_d;
  logic           rw_q, rw_d;
  logic           dma_act_q, dma_act_d;
  logic           word_done_q, word_done_d;
  logic           buserr_q, buserr_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BGW-1:0] bg_tmr_q, bg_tmr_d;
  logic [DTW-1:0] dt_tmr_q, dt_tmr_d;
  logic           tick;

  assign tick = ~i_CLK4M_PCEN_n;

  // State and output registers; reset overrides the clock enable.
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      state_q     <= ST_IDLE;
      br_n_q      <= 1'b1;
      bgack_n_q   <= 1'b1;
      as_n_q      <= 1'b1;
      ds_n_q      <= 1'b1;
      rw_q        <= 1'b1;
      dma_act_q   <= 1'b0;
      word_done_q <= 1'b0;
      buserr_q    <= 1'b0;
      addr_q      <= '0;
      bg_tmr_q    <= '0;
      dt_tmr_q    <= '0;
    end else begin
      state_q     <= state_d;
      br_n_q      <= br_n_d;
      bgack_n_q   <= bgack_n_d;
      as_n_q      <= as_n_d;
      ds_n_q      <= ds_n_d;
      rw_q        <= rw_d;
      dma_act_q   <= dma_act_d;
      word_done_q <= word_done_d;
      buserr_q    <= buserr_d;
      addr_q      <= addr_d;
      bg_tmr_q    <= bg_tmr_d;
      dt_tmr_q    <= dt_tmr_d;
    end
  end

  // Next-state and output decode; everything holds between clock-enable ticks.
  always_comb begin
    state_d     = state_q;
    br_n_d      = br_n_q;
    bgack_n_d   = bgack_n_q;
    as_n_d      = as_n_q;
    ds_n_d      = ds_n_q;
    rw_d        = rw_q;
    dma_act_d   = dma_act_q;
    word_done_d = word_done_q;
    buserr_d    = buserr_q;
    addr_d      = addr_q;
    bg_tmr_d    = bg_tmr_q;
    dt_tmr_d    = dt_tmr_q;

    if (tick) begin
      word_done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_ADDR_LD) addr_d = i_ADDR_D;
          if (!i_BR_START_n) begin
            state_d  = ST_REQ;
            br_n_d   = 1'b0;
            buserr_d = 1'b0;
            bg_tmr_d = '0;
          end
        end
        ST_REQ: begin
          if (i_ADDR_LD) addr_d = i_ADDR_D;
          // Grant is only taken once the previous master has fully left the bus.
          if (!i_BG_n && i_AS_n && i_DTACK_n) begin
            state_d   = ST_OWN;
            br_n_d    = 1'b1;
            bgack_n_d = 1'b0;
            dma_act_d = 1'b1;
          end else if (i_DMA_END) begin
            state_d = ST_IDLE;
            br_n_d  = 1'b1;
          end else if (bg_tmr_q == BGW'(BG_TMO - 1)) begin
            state_d  = ST_IDLE;
            br_n_d   = 1'b1;
            buserr_d = 1'b1;
          end else begin
            bg_tmr_d = bg_tmr_q + BGW'(1);
          end
        end
        ST_OWN: begin
          if (i_WORD_REQ) begin
            state_d = ST_AS;
          end else if (i_DMA_END) begin
            state_d = ST_REL;
          end
        end
        ST_AS: begin
          state_d  = ST_DS;
          as_n_d   = 1'b0;
          rw_d     = i_DMA_WR_ACT_n;
          dt_tmr_d = '0;
        end
        ST_DS: begin
          state_d = ST_WT;
          ds_n_d  = 1'b0;
        end
        ST_WT: begin
          if (!i_DTACK_n) begin
            state_d = ST_END;
          end else if (dt_tmr_q == DTW'(DTACK_TMO - 1)) begin
            state_d  = ST_REL;
            as_n_d   = 1'b1;
            ds_n_d   = 1'b1;
            rw_d     = 1'b1;
            buserr_d = 1'b1;
          end else begin
            dt_tmr_d = dt_tmr_q + DTW'(1);
          end
        end
        ST_END: begin
          state_d     = ST_OWN;
          as_n_d      = 1'b1;
          ds_n_d      = 1'b1;
          rw_d        = 1'b1;
          word_done_d = 1'b1;
          addr_d      = addr_q + AW'(1);
        end
        ST_REL: begin
          state_d   = ST_IDLE;
          bgack_n_d = 1'b1;
          dma_act_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_BR_n      = br_n_q;
  assign o_BGACK_n   = bgack_n_q;
  assign o_AS_n      = as_n_q;
  assign o_UDS_n     = ds_n_q;
  assign o_LDS_n     = ds_n_q;
  assign o_RW        = rw_q;
  assign o_ADDR      = addr_q;
  assign o_DMA_ACT   = dma_act_q;
  assign o_WORD_DONE = word_done_q;
  assign o_BUSERR    = buserr_q;

  // Bus ownership invariants.
  a_br_bgack_excl : assert property (@(posedge i_MCLK) disable iff (i_SYS_RST) (br_n_q || bgack_n_q));
  a_as_needs_own  : assert property (@(posedge i_MCLK) disable iff (i_SYS_RST) (as_n_q || !bgack_n_q));

endmodule
